// File: rtl/icache_assoc_if.sv
// Fetch-side, memory-side and maintenance signals of the two-way instruction cache.
// slave: the cache's view (takes fetches and refill data, drives responses and refill requests).
// master: the environment's view (fetch unit plus memory controller).
interface icache_assoc_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        flush;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  fetch_req, fetch_addr, mem_valid, mem_data, flush,
        output fetch_valid, fetch_data, mem_req, mem_addr, hit_cnt, miss_cnt
    );

    modport master (
        output fetch_req, fetch_addr, mem_valid, mem_data, flush,
        input  fetch_valid, fetch_data, mem_req, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_assoc.sv
// Two-way set-associative instruction cache, multi-word lines, per-set LRU, word-serial refill.
// Latency: hit answers one cycle after the request; miss answers one cycle after the last refill beat.
// Backpressure: rdy_in low freezes everything; mem_req holds until mem_valid; fetch_req seen only in IDLE.
// Ports: clk_in/rst_in (async active-high), rdy_in pause, bus = fetch req/resp, refill req/data,
//        flush, hit/miss counters. Define ICACHE_PERF_EN to build the hit/miss counters.
module icache_assoc #(
    parameter int SET_BITS       = 4,
    parameter int LINE_WORD_BITS = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    icache_assoc_if.slave bus
);
    localparam int SETS       = 1 << SET_BITS;
    localparam int LINE_WORDS = 1 << LINE_WORD_BITS;
    localparam int IDX_LSB    = 2 + LINE_WORD_BITS;
    localparam int TAG_LSB    = IDX_LSB + SET_BITS;
    localparam int TAG_W      = 32 - TAG_LSB;

    typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, RESP = 2'd2} state_t;

    state_t state_q, state_d;

    // Line storage; data and tags carry no reset, only the valid bits matter after reset.
    logic [31:0]          data_q [2][SETS*LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;      // way to evict next

    logic [31:2]               req_addr_q;  // latched miss address; drives all refill addressing
    logic                      victim_q;
    logic [LINE_WORD_BITS-1:0] beat_q;
    logic                      hit_vld_q;
    logic [31:0]               fetch_data_q;

    logic [SET_BITS-1:0]       req_idx, lat_idx;
    logic [LINE_WORD_BITS-1:0] req_off, lat_off;
    logic [TAG_W-1:0]          req_tag, lat_tag;
    logic [1:0]                hit_way;
    logic                      hit, hit_w, victim;
    logic                      accept, beat_fire, last_beat;
    logic                      unused_addr_bits;

    assign req_idx = bus.fetch_addr[IDX_LSB +: SET_BITS];
    assign req_off = bus.fetch_addr[2 +: LINE_WORD_BITS];
    assign req_tag = bus.fetch_addr[31:TAG_LSB];
    assign lat_idx = req_addr_q[IDX_LSB +: SET_BITS];
    assign lat_off = req_addr_q[2 +: LINE_WORD_BITS];
    assign lat_tag = req_addr_q[31:TAG_LSB];
    assign unused_addr_bits = ^bus.fetch_addr[1:0];

    assign hit_way[0] = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit_way[1] = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit        = |hit_way;
    assign hit_w      = ~hit_way[0];
    // Fill an empty way first (way 0 before way 1); only evict by LRU when the set is full.
    assign victim     = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    assign accept    = (state_q == IDLE) && bus.fetch_req && !bus.flush;
    assign beat_fire = (state_q == REFILL) && bus.mem_valid;
    assign last_beat = &beat_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_req     = 1'b0;
        bus.mem_addr    = '0;
        bus.fetch_valid = hit_vld_q;
        bus.fetch_data  = fetch_data_q;
        case (state_q)
            IDLE: begin
                if (accept && !hit) state_d = REFILL;
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {req_addr_q[31:IDX_LSB], beat_q, 2'b00};
                if (beat_fire && last_beat) state_d = RESP;
            end
            RESP: begin
                // A flush in this cycle kills the response.
                bus.fetch_valid = !bus.flush;
                bus.fetch_data  = data_q[victim_q][{lat_idx, lat_off}];
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q      <= '0;
            lru_q        <= '0;
            req_addr_q   <= '0;
            victim_q     <= 1'b0;
            beat_q       <= '0;
            hit_vld_q    <= 1'b0;
            fetch_data_q <= '0;
        end else if (rdy_in) begin
            hit_vld_q <= accept && hit;
            if (bus.flush) begin
                valid_q <= '0;
                lru_q   <= '0;
            end else if (accept) begin
                if (hit) begin
                    fetch_data_q   <= data_q[hit_w][{req_idx, req_off}];
                    lru_q[req_idx] <= ~hit_w;
                end else begin
                    req_addr_q               <= bus.fetch_addr[31:2];
                    victim_q                 <= victim;
                    valid_q[victim][req_idx] <= 1'b0;
                    beat_q                   <= '0;
                end
            end else if (beat_fire) begin
                beat_q <= beat_q + 1'b1;
                if (last_beat) begin
                    valid_q[victim_q][lat_idx] <= 1'b1;
                    lru_q[lat_idx]             <= ~victim_q;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !bus.flush && beat_fire) begin
            data_q[victim_q][{lat_idx, beat_q}] <= bus.mem_data;
            if (last_beat) tag_q[victim_q][lat_idx] <= lat_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in && accept) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: fetches push expected words, a monitor pops them on fetch_valid.
// Memory model answers every refill beat in the same cycle with word(a) = 0xA0 + a/4 - 0x40.
module tb_icache_assoc;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    icache_assoc_if bus ();

    icache_assoc dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

`ifdef ICACHE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];
    int          beats = 0;
    int          mem_budget = -1;   // beats the memory will still answer; -1 = unlimited
    logic        mon_prev = 1'b0;
    int          pb0;
    logic [31:0] pa0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2) - 32'h40;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Memory model: one-cycle response; a beat counts only when the cache is not paused.
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && mem_budget != 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = mem_word(bus.mem_addr);
                if (rdy) begin
                    beats++;
                    addr_log.push_back(bus.mem_addr);
                    if (mem_budget > 0) mem_budget--;
                end
            end else begin
                bus.mem_valid = 1'b0;
                bus.mem_data  = '0;
            end
        end
    end

    // Monitor: every fetch_valid must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
            end else if (rdy) begin
                if (bus.fetch_valid) begin
                    if (mon_prev) begin
                        tests++;
                        fails++;
                        $display("FAIL double_pulse: fetch_valid high two cycles, expected one");
                    end
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_valid: fetch_data %h, expected no response", bus.fetch_data);
                    end else begin
                        chk("fetch_data", bus.fetch_data, exp_q.pop_front());
                    end
                end
                mon_prev = bus.fetch_valid;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int exp_beats,
                         input int exp_lat, input string nm);
        int b0;
        int lat;
        bit got;
        @(posedge clk); #1;
        b0  = beats;
        lat = 0;
        got = 1'b0;
        exp_q.push_back(d);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.fetch_valid) got = 1'b1;
        end
        bus.fetch_req = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no fetch_valid in 100 cycles, expected one", nm);
            void'(exp_q.pop_back());
        end else begin
            chk({nm, "_latency"}, lat, exp_lat);
            chk({nm, "_beats"}, beats - b0, exp_beats);
        end
    endtask

    task automatic wait_beats(input int base, input int n, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (beats - base >= n) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: refill beats %0d, expected at least %0d", nm, beats - base, n);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_fetch_valid"}, bus.fetch_valid, 0);
        chk({nm, "_fetch_data"},  bus.fetch_data,  0);
        chk({nm, "_mem_req"},     bus.mem_req,     0);
        chk({nm, "_mem_addr"},    bus.mem_addr,    0);
        chk({nm, "_hit_cnt"},     bus.hit_cnt,     0);
        chk({nm, "_miss_cnt"},    bus.miss_cnt,    0);
    endtask

    initial begin
        rst            = 1'b1;
        rdy            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.flush      = 1'b0;
        #12;
        chk_all_zero("reset");
        rst = 1'b0;

        // Cold miss then hit in the same line.
        addr_log.delete();
        fetch(32'h100, 32'hA0, 4, 5, "cold_miss");
        chk("refill_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("refill_addr", addr_log[i], 32'h100 + 32'(4 * i));
        fetch(32'h104, 32'hA1, 0, 1, "hit_0x104");

        // Flush after two refill beats.
        mem_budget = 2;
        pb0 = beats;
        @(posedge clk); #1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h300;
        wait_beats(pb0, 2, "flush_wait");
        chk("refill_active", bus.mem_req, 1);
        bus.flush     = 1'b1;
        bus.fetch_req = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_mem_req", bus.mem_req, 0);
        chk("flush_no_valid", bus.fetch_valid, 0);
        mem_budget = -1;
        @(posedge clk); #1;
        chk("flush_mem_req_stays", bus.mem_req, 0);
        fetch(32'h300, 32'h120, 4, 5, "refetch_after_flush");
        fetch(32'h100, 32'hA0, 4, 5, "flushed_line_miss");
        fetch(32'h30C, 32'h123, 0, 1, "hit_0x30C");

        // Conflict in set 0 from an empty cache.
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        fetch(32'h000, 32'h60,  4, 5, "fill_0x000");
        fetch(32'h400, 32'h160, 4, 5, "fill_0x400");
        fetch(32'h000, 32'h60,  0, 1, "touch_0x000");
        fetch(32'h800, 32'h260, 4, 5, "fill_0x800");
        fetch(32'h000, 32'h60,  0, 1, "keep_0x000");
        fetch(32'h400, 32'h160, 4, 5, "evicted_0x400");

        // Five-cycle pause in the middle of a refill with memory offering data.
        pb0 = beats;
        fork
            fetch(32'h148, 32'hB2, 4, 10, "pause_refill");
            begin
                wait_beats(pb0, 2, "pause_wait");
                pa0 = bus.mem_addr;
                chk("pause_addr_before", pa0, 32'h148);
                rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("pause_addr_held", bus.mem_addr, 32'h148);
                chk("pause_mem_req", bus.mem_req, 1);
                chk("pause_beats_held", beats - pb0, 2);
                chk("pause_no_valid", bus.fetch_valid, 0);
                rdy = 1'b1;
            end
        join

        // Asynchronous reset mid-refill.
        mem_budget = 2;
        pb0 = beats;
        @(posedge clk); #1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h200;
        wait_beats(pb0, 2, "reset_wait");
        #2;
        rst           = 1'b1;
        bus.fetch_req = 1'b0;
        #1;
        chk_all_zero("async_reset");
        mem_budget = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(32'h148, 32'hB2, 4, 5, "miss_after_reset");
        fetch(32'h140, 32'hB0, 0, 1, "hit_0x140");
        fetch(32'h144, 32'hB1, 0, 1, "hit_0x144");
        fetch(32'h14C, 32'hB3, 0, 1, "hit_0x14C");
        @(posedge clk); #1;
        chk("hit_cnt", bus.hit_cnt, PERF ? 32'd3 : 32'd0);
        chk("miss_cnt", bus.miss_cnt, PERF ? 32'd1 : 32'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
